// File: rtl/mixcol_column_sched.sv
// mixcol_column_sched: shares one 32-bit MixColumns unit across the four columns of an AES state
module mixcol_column_sched #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic [31:0]  mc_x,
  output logic         mc_en,
  input  logic [31:0]  mc_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_n;
  logic [1:0] col;
  logic [127:0] src, res;
  logic last_col;
  assign last_col = col == 2'(NCOL - 1);
  always_ff @(posedge clk) st <= rst ? IDLE : st_n;
  always_comb begin
    st_n = st;
    if (st == IDLE && in_valid) st_n = in_last ? DONE : RUN;
    else if (st == RUN && last_col) st_n = DONE;
    else if (st == DONE && out_ready) st_n = IDLE;
  end
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  assign busy      = st != IDLE;
  assign mc_en     = st == RUN;
  assign mc_x      = mc_en ? src[127 - 32*col -: 32] : 32'h0;
  assign out_state = res;
  // the final-round bypass loads the result directly, skipping RUN entirely
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      src <= '0;
      res <= '0;
    end else if (st == IDLE && in_valid) begin
      src <= in_state;
      col <= '0;
      if (in_last) res <= in_state;
    end else if (st == RUN) begin
      res[127 - 32*col -: 32] <= mc_y;
      col <= last_col ? col : col + 2'd1;
    end
endmodule

// File: tb/tb_mixcol_column_sched.sv
// tb_mixcol_column_sched: table vectors, corner sequences and random streaming against a MixColumns model
module tb_mixcol_column_sched;
  logic clk = 0;
  logic rst, in_valid, in_ready, in_last, mc_en, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;
  logic [31:0] mc_x, mc_y;
  int n_vec = 0, n_bad = 0;
  logic [31:0] mcq[$];
  logic [127:0] expq[$];
  always #5 clk = ~clk;

  mixcol_column_sched #(.NCOL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_last(in_last), .mc_x(mc_x), .mc_en(mc_en), .mc_y(mc_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic l);
    logic [127:0] r;
    if (l) return s;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix(s[127 - 32*c -: 32]);
    return r;
  endfunction

  assign mc_y = mix(mc_x);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mc_en) mcq.push_back(mc_x);
    if (!rst) chk("busy", busy, !in_ready);
  end

  task automatic xfer(input logic [127:0] s, input logic l, output logic [127:0] got, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    mcq.delete();
    in_valid = 1; in_state = s; in_last = l;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    got = out_state;
  endtask

  typedef struct {
    string        name;
    logic [127:0] st;
    logic         last;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  initial begin
    vec_t tv[3];
    logic [127:0] got, cat;
    int lat;
    tv[0] = '{"fips", FIPS_IN, 1'b0, FIPS_OUT, 5};
    tv[1] = '{"second", 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
              128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 5};
    tv[2] = '{"bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
              128'h00112233_44556677_8899aabb_ccddeeff, 1};
    rst = 1; in_valid = 0; in_state = '0; in_last = 0; out_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst mc_en", mc_en, 0);
    chk("rst busy", busy, 0);
    chk("rst mc_x", mc_x, 0);
    chk("rst out_state", out_state, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      xfer(tv[i].st, tv[i].last, got, lat);
      chk({tv[i].name, " state"}, got, tv[i].exp);
      chk({tv[i].name, " latency"}, lat, tv[i].lat);
      chk({tv[i].name, " mc count"}, mcq.size(), tv[i].last ? 0 : 4);
      cat = '0;
      foreach (mcq[k]) cat = {cat[95:0], mcq[k]};
      chk({tv[i].name, " mc_x seq"}, cat, tv[i].last ? 128'h0 : tv[i].st);
      @(negedge clk);
    end
    // backpressure: result held, new input ignored until released
    out_ready = 0;
    xfer(FIPS_IN, 0, got, lat);
    chk("bp latency", lat, 5);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; in_state = ~FIPS_IN; in_last = 1;
      @(negedge clk);
      chk("bp state", out_state, FIPS_OUT);
      chk("bp in_ready", in_ready, 0);
      chk("bp out_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("release in_ready", in_ready, 1);
    chk("release out_valid", out_valid, 0);
    // reset while column 2 is on the bus
    in_valid = 1; in_state = FIPS_IN; in_last = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("run col2 mc_x", mc_x, 32'h01010101);
    rst = 1;
    @(negedge clk);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst mc_en", mc_en, 0);
    chk("mid rst out_state", out_state, 0);
    rst = 0;
    @(negedge clk);
    xfer(FIPS_IN, 0, got, lat);
    chk("post rst state", got, FIPS_OUT);
    chk("post rst latency", lat, 5);
    @(negedge clk);
    // random streaming with random downstream stalls
    fork
      begin
        logic [127:0] s;
        logic l;
        int t;
        for (int i = 0; i < 20; i++) begin
          s = {$urandom(), $urandom(), $urandom(), $urandom()};
          l = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 3)) @(negedge clk);
          in_valid = 1; in_state = s; in_last = l;
          t = 0;
          while (!in_ready && t < 200) begin @(negedge clk); t++; end
          if (in_ready) expq.push_back(model(s, l));
          @(negedge clk);
          in_valid = 0;
        end
      end
      begin
        int got_n, t;
        got_n = 0; t = 0;
        while (got_n < 20 && t < 3000) begin
          @(negedge clk);
          t++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            chk("stream out", out_state, expq.size() != 0 ? expq.pop_front() : 'x);
            got_n++;
          end
        end
        chk("stream count", got_n, 20);
      end
    join
    out_ready = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mixcol_column_sched.md
# mixcol_column_sched

Column scheduler that shares a single 32-bit MixColumns unit across the four columns of a 128-bit AES state. It accepts a full state over a valid/ready handshake and feeds one column per cycle to the external MixColumns datapath. It captures each transformed column and returns the assembled 128-bit state over a second valid/ready handshake. It sits between the ShiftRows stage and the AddRoundKey stage of the iterative round datapath. On the final round it bypasses MixColumns.

## Interface
Parameters:
- `NCOL`, 4, number of columns per state; fixed at 4 for AES-128 state width.

Ports:
- `clk`  input  1  rising-edge clock; the block uses one clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  upstream state available.
- `in_ready`  output  1  block can accept a state.
- `in_state`  input  128  state; column c = `in_state[127-32c -: 32]`.
- `in_last`  input  1  final round; bypass MixColumns. Sampled with `in_state`.
- `mc_x`  output  32  column driven to the shared MixColumns unit.
- `mc_en`  output  1  high when `mc_x` carries a valid column.
- `mc_y`  input  32  combinational MixColumns result for `mc_x`, same cycle.
- `out_valid`  output  1  result state available.
- `out_ready`  input  1  downstream accepts result.
- `out_state`  output  128  result, with the same column layout as `in_state`.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_state` into an internal 128-bit register and latch `in_last`.
  - If `in_last`=1: copy the latched state to the result register and go to DONE.
  - Otherwise: clear the 2-bit column counter `col` and go to RUN.
- RUN:
  - `mc_x` = latched column `col`; `mc_en`=1.
  - Each cycle, `mc_y` is written into result column `col`.
  - `col` increments each cycle. It does not wrap: when `col`==3 is written, go to DONE.
  - `in_valid` is ignored during RUN.
- DONE:
  - `out_valid`=1 and `out_state` = result register.
  - On `out_ready`: go to IDLE.
  - While stalled, `out_state` is held stable.
- Outside RUN: `mc_x`=32'h0 and `mc_en`=0.
- The block is encoding-agnostic. It never inverts or masks bytes; any inversion masking belongs to the MixColumns unit. In bypass mode the output equals the input bit-for-bit.
- Back-to-back operation: `in_ready` is high only in IDLE, so there is no overlap between consecutive states.
- Reset values:
  - State = IDLE, `col`=0.
  - `in_ready`=1, `out_valid`=0, `mc_en`=0, `busy`=0.
  - `mc_x`=0, `out_state`=0.
- Reset mid-operation, in RUN or DONE: the partial or unconsumed result is discarded and the result register is cleared.

## Timing
- Accept at edge T: `mc_en` is high during cycles T+1..T+4, with columns 0,1,2,3 in order.
- `out_valid` rises after edge T+4, so latency from accept to `out_valid` is 5 cycles.
- Bypass: `out_valid` is high in the cycle after accept (1 cycle). `mc_en` stays 0 throughout.
- Minimum initiation interval:
  - 6 cycles for the MixColumns path, with `out_ready` tied high.
  - 2 cycles for the bypass path.
- `out_ready` held low: the block stays in DONE indefinitely and `in_ready` stays 0.
- `rst` asserted in any cycle takes priority over all handshakes in that cycle.
- `in_ready` and `out_valid` are registered-state decodes. They have no combinational path from `in_valid` or `out_ready`.

## Test plan
All scenarios connect a standard (unmasked) MixColumns model to `mc_x`/`mc_y`.
- FIPS-197 vector:
  - Stimulus: `in_state`=db135345_f20a225c_01010101_c6c6c6c6, `in_last`=0, `out_ready`=1.
  - Required: `out_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6 and `out_valid` exactly 5 cycles after accept.
  - Required: `mc_x` sequence db135345, f20a225c, 01010101, c6c6c6c6.
- Second vector:
  - Stimulus: `in_state`=d4d4d4d5_2d26314c_00000000_ffffffff.
  - Required: `out_state`=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Bypass:
  - Stimulus: `in_last`=1, `in_state`=00112233_44556677_8899aabb_ccddeeff.
  - Required: `out_state` identical to `in_state`, `out_valid` 1 cycle after accept, `mc_en` never high.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Required: `out_state` stable, `in_ready`=0 and `in_valid` ignored throughout.
  - Required: release `out_ready` → `in_ready`=1 on the next cycle.
- Reset during RUN:
  - Stimulus: assert `rst` when `col`=2.
  - Required: next cycle state IDLE, `out_valid`=0, `mc_en`=0, `out_state`=0.
  - Required: a fresh FIPS vector afterwards completes correctly.
- Streaming:
  - Stimulus: 20 random states with random `in_last` and random `out_ready` stalls.
  - Required: outputs in order and matching the model; `busy` equals !(IDLE) every cycle.
